// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: state encoding and constants shared by the FP adder arbiter.
package fp_arb_pkg;
  localparam int DATA_W = 32;
  localparam int NREQ_DEF = 4;
  localparam int TIMEOUT_DEF = 32;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/fp_rr_picker.sv
// fp_rr_picker: picks the first set request at or above rr_ptr, wrapping modulo NREQ.
module fp_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any_req
);
  localparam int IW = $clog2(NREQ);
  // Scan farthest-first so the candidate closest to rr_ptr overwrites the rest.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    any_req = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        grant = NREQ'(1) << ((int'(rr_ptr) + k) % NREQ);
        grant_idx = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one FP adder among NREQ requesters.
// Define FP_ARB_TIMEOUT_EN to add a WAIT watchdog that answers with a quiet NaN and rsp_err.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      fpu_a,
  output logic [DATA_W-1:0]      fpu_b,
  output logic                   fpu_start,
  input  logic                   fpu_done,
  input  logic [DATA_W-1:0]      fpu_sum
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, grant_id, pick_idx;
  logic [NREQ-1:0] pick;
  logic any_req, hs, timeout;
  fp_rr_picker #(.NREQ(NREQ)) u_picker (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .grant(pick),
    .grant_idx(pick_idx),
    .any_req(any_req)
  );
  assign hs = state == IDLE && any_req;
`ifdef FP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  assign timeout = wait_cnt == CW'(TIMEOUT - 1);
  // Held at zero outside WAIT, so every WAIT entry starts counting from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wait_cnt <= '0;
    else wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rsp_err <= 1'b0;
    else if (state == WAIT && (fpu_done || timeout)) rsp_err <= !fpu_done;
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE  ? (hs ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? ((fpu_done || timeout) ? RESP : WAIT) : IDLE;
    req_ready = state == IDLE ? pick : '0;
    fpu_start = state == ISSUE;
    rsp_valid = state == RESP ? NREQ'(1) << grant_id : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fpu_a <= '0;
      fpu_b <= '0;
      rsp_sum <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
    end else begin
      if (hs) begin
        fpu_a <= req_a[DATA_W*pick_idx +: DATA_W];
        fpu_b <= req_b[DATA_W*pick_idx +: DATA_W];
        grant_id <= pick_idx;
      end
      if (state == WAIT && (fpu_done || timeout)) rsp_sum <= fpu_done ? fpu_sum : QNAN;
      if (state == RESP) rr_ptr <= grant_id == IW'(NREQ - 1) ? '0 : grant_id + 1'b1;
    end
  end
endmodule
